// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers for the max-select and round-robin arbiters.
package arb_pkg;

  localparam int TIE_HIGH = 0;
  localparam int TIE_LOW  = 1;

  localparam int MAX_IW = 5;
  localparam int MAX_W  = 32;

  typedef logic [MAX_IW-1:0] arb_idx_t;
  typedef logic [MAX_W-1:0]  arb_val_t;

  typedef struct packed {
    arb_val_t val;
    arb_idx_t idx;
    logic     tie;
  } arb_cand_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/max_cmp_node.sv
// One compare-tree node: picks the larger of two candidates and registers the winner
// while the pipeline is not stalled.
module max_cmp_node
  import arb_pkg::*;
#(
  parameter int W        = 8,
  parameter int IW_IN    = 2,
  parameter int TIE_MODE = TIE_HIGH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [W-1:0]     a_val,
  input  logic [IW_IN-1:0] a_idx,
  input  logic             a_tie,
  input  logic [W-1:0]     b_val,
  input  logic [IW_IN-1:0] b_idx,
  input  logic             b_tie,
  output logic [W-1:0]     val_q,
  output logic [IW_IN-1:0] idx_q,
  output logic             tie_q
);

  logic             b_wins;
  logic [W-1:0]     val_d;
  logic [IW_IN-1:0] idx_d;
  logic             tie_d;

  // a is always the lower-index half, so equal values resolve by TIE_MODE alone.
  always_comb begin
    b_wins = (b_val > a_val) || ((b_val == a_val) && (TIE_MODE == TIE_HIGH));
    val_d  = val_q;
    idx_d  = idx_q;
    tie_d  = tie_q;
    if (en) begin
      val_d = b_wins ? b_val : a_val;
      idx_d = b_wins ? b_idx : a_idx;
      tie_d = (a_val == b_val) | (b_wins ? b_tie : a_tie);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      idx_q <= '0;
      tie_q <= 1'b0;
    end else begin
      val_q <= val_d;
      idx_q <= idx_d;
      tie_q <= tie_d;
    end
  end

endmodule

// File: rtl/max_select_arbiter_pipe.sv
// Pipelined max-value arbiter: heap-ordered compare tree of N-1 registered nodes,
// one stage per level, with a matching valid pipe and global stall.
module max_select_arbiter_pipe
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int W        = 8,
  parameter  int TIE_MODE = TIE_HIGH,
  localparam int IW       = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IW-1:0]  out_idx,
  output logic [W-1:0]   out_max,
  output logic           out_tie
);

  logic          stall;
  logic [IW-1:0] vld_q;
  logic [IW-1:0] vld_d;

  // Heap layout: node i has children 2i (lower index) and 2i+1; channel k is leaf N+k.
  logic [W-1:0]  t_val [1:2*N-1];
  logic [IW-1:0] t_idx [1:2*N-1];
  logic          t_tie [1:2*N-1];

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = vld_q[IW-1];
  assign out_max   = t_val[1];
  assign out_idx   = t_idx[1];
  assign out_tie   = t_tie[1];

  for (genvar k = 0; k < N; k++) begin : g_leaf
    assign t_val[N+k] = in_data[k*W +: W];
    assign t_idx[N+k] = IW'(k);
    assign t_tie[N+k] = 1'b0;
  end

  for (genvar i = 1; i < N; i++) begin : g_node
    max_cmp_node #(
      .W        (W),
      .IW_IN    (IW),
      .TIE_MODE (TIE_MODE)
    ) u_node (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (!stall),
      .a_val (t_val[2*i]),
      .a_idx (t_idx[2*i]),
      .a_tie (t_tie[2*i]),
      .b_val (t_val[2*i+1]),
      .b_idx (t_idx[2*i+1]),
      .b_tie (t_tie[2*i+1]),
      .val_q (t_val[i]),
      .idx_q (t_idx[i]),
      .tie_q (t_tie[i])
    );
  end

  always_comb begin
    vld_d = vld_q;
    if (!stall) begin
      vld_d[0] = in_valid;
      for (int s = 1; s < IW; s++) vld_d[s] = vld_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

endmodule

// File: tb/tb_max_select_arbiter_pipe.sv
// Self-checking bench: directed scenarios plus a random stream against a flat-scan reference.
module tb_max_select_arbiter_pipe;

  typedef struct {
    int     idx;
    longint mx;
    bit     tie;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // N=4,W=8 pair sharing one input stream, differing only in tie-break
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready0, out_valid0, tie0, in_ready1, out_valid1, tie1;
  logic [1:0]  idx0, idx1;
  logic [7:0]  max0, max1;

  // N=8,W=16
  logic         v8 = 1'b0, ordy8 = 1'b0, ir8, ov8, tie8;
  logic [127:0] d8 = '0;
  logic [2:0]   idx8;
  logic [15:0]  max8;

  // N=2,W=8
  logic        v2 = 1'b0, ordy2 = 1'b0, ir2, ov2, tie2;
  logic [15:0] d2 = '0;
  logic [0:0]  idx2;
  logic [7:0]  max2;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q0[$], q1[$];

  max_select_arbiter_pipe #(.N(4), .W(8), .TIE_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_idx(idx0), .out_max(max0), .out_tie(tie0));

  max_select_arbiter_pipe #(.N(4), .W(8), .TIE_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_idx(idx1), .out_max(max1), .out_tie(tie1));

  max_select_arbiter_pipe #(.N(8), .W(16), .TIE_MODE(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_data(d8),
    .out_valid(ov8), .out_ready(ordy8), .out_idx(idx8), .out_max(max8), .out_tie(tie8));

  max_select_arbiter_pipe #(.N(2), .W(8), .TIE_MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2), .in_data(d2),
    .out_valid(ov2), .out_ready(ordy2), .out_idx(idx2), .out_max(max2), .out_tie(tie2));

  // Reference: find the maximum, then pick the highest (mode 0) or lowest (mode 1) channel holding it.
  function automatic exp_t ref_scan(input logic [127:0] d, input int n, input int w, input int mode);
    exp_t   e;
    longint v [32];
    int     cnt;
    logic [127:0] t;
    e.mx = 0;
    for (int k = 0; k < n; k++) begin
      t    = (d >> (k * w)) & ((128'd1 << w) - 1);
      v[k] = longint'(t[31:0]);
      if (v[k] > e.mx) e.mx = v[k];
    end
    cnt   = 0;
    e.idx = -1;
    for (int k = 0; k < n; k++) begin
      if (v[k] == e.mx) begin
        cnt++;
        if (mode == 0 || e.idx < 0) e.idx = k;
      end
    end
    e.tie = (cnt >= 2);
    return e;
  endfunction

  // Stimulus helper: one transaction into the N=4 pair, waits for the result; returns latency in edges.
  task automatic send_one(input logic [31:0] d, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = $urandom;
    lat = 1;
    while (!out_valid0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    n_cmp++;
    if (out_valid0 !== 1'b0 || idx0 !== 2'd0 || max0 !== 8'd0 || tie0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b idx=%0d max=%0h tie=%b, want all 0", out_valid0, idx0, max0, tie0);
    end
    n_cmp++;
    if (ov8 !== 1'b0 || ov2 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid_others: got v1=%b v8=%b v2=%b, want 0", out_valid1, ov8, ov2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready0, out_valid0);
    end
  endtask

  task automatic test_basic();
    int lat;
    send_one(32'h10_40_22_07, lat);
    n_cmp++;
    if (lat != 2 || idx0 !== 2'd2 || max0 !== 8'h40 || tie0 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_m0: got lat=%0d idx=%0d max=%0h tie=%b, want 2/2/40/0", lat, idx0, max0, tie0);
    end
    n_cmp++;
    if (out_valid1 !== 1'b1 || idx1 !== 2'd2 || max1 !== 8'h40 || tie1 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_m1: got v=%b idx=%0d max=%0h tie=%b, want 1/2/40/0", out_valid1, idx1, max1, tie1);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid0 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_drain: got out_valid=%b, want 0", out_valid0);
    end
  endtask

  task automatic test_ties();
    logic [31:0] pat [3];
    int e0 [3];
    int e1 [3];
    int emx [3];
    int lat;
    pat = '{32'hFF_FF_FF_FF, 32'h05_09_09_01, 32'h00_00_00_00};
    e0  = '{3, 2, 3};
    e1  = '{0, 1, 0};
    emx = '{255, 9, 0};
    for (int i = 0; i < 3; i++) begin
      send_one(pat[i], lat);
      n_cmp++;
      if (idx0 !== 2'(e0[i]) || max0 !== 8'(emx[i]) || tie0 !== 1'b1) begin
        n_err++;
        $display("FAIL ties_m0[%0d]: got idx=%0d max=%0h tie=%b, want %0d/%0h/1", i, idx0, max0, tie0, e0[i], emx[i]);
      end
      n_cmp++;
      if (idx1 !== 2'(e1[i]) || max1 !== 8'(emx[i]) || tie1 !== 1'b1) begin
        n_err++;
        $display("FAIL ties_m1[%0d]: got idx=%0d max=%0h tie=%b, want %0d/%0h/1", i, idx1, max1, tie1, e1[i], emx[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] items [6];
    logic [10:0] snap;
    int sent, got;
    exp_t e;
    sent = 0; got = 0; snap = '0;
    q0.delete(); q1.delete();
    for (int i = 0; i < 6; i++) items[i] = $urandom;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 6);
      in_data   = (sent < 6) ? items[sent] : 32'h0;
      #1;
      n_cmp++;
      if (in_ready0 !== !(c >= 3 && c <= 5)) begin
        n_err++;
        $display("FAIL bp_in_ready c=%0d: got %b, want %b", c, in_ready0, !(c >= 3 && c <= 5));
      end
      if (c == 3) snap = {out_valid0, idx0, max0};
      if (c == 4 || c == 5) begin
        n_cmp++;
        if ({out_valid0, idx0, max0} !== snap) begin
          n_err++;
          $display("FAIL bp_stable c=%0d: got %h, want %h", c, {out_valid0, idx0, max0}, snap);
        end
      end
      if (out_valid0 && out_ready) begin
        n_cmp++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra_m0: got idx=%0d max=%0h, want no result", idx0, max0);
        end else begin
          e = q0.pop_front();
          got++;
          if (idx0 !== 2'(e.idx) || max0 !== 8'(e.mx) || tie0 !== e.tie) begin
            n_err++;
            $display("FAIL bp_data_m0: got idx=%0d max=%0h tie=%b, want %0d/%0h/%b", idx0, max0, tie0, e.idx, e.mx, e.tie);
          end
        end
      end
      if (out_valid1 && out_ready) begin
        n_cmp++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL bp_extra_m1: got idx=%0d max=%0h, want no result", idx1, max1);
        end else begin
          e = q1.pop_front();
          if (idx1 !== 2'(e.idx) || max1 !== 8'(e.mx) || tie1 !== e.tie) begin
            n_err++;
            $display("FAIL bp_data_m1: got idx=%0d max=%0h tie=%b, want %0d/%0h/%b", idx1, max1, tie1, e.idx, e.mx, e.tie);
          end
        end
      end
      if (in_valid && in_ready0) begin
        q0.push_back(ref_scan({96'h0, in_data}, 4, 8, 0));
        q1.push_back(ref_scan({96'h0, in_data}, 4, 8, 1));
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (got != 6 || q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: got %0d delivered, left %0d/%0d, want 6 delivered, 0 left", got, q0.size(), q1.size());
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    stale = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h01_02_03_04; out_ready = 1'b1;
    @(negedge clk);
    in_data = 32'h80_00_00_00;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid0 !== 1'b0 || max0 !== 8'd0 || idx0 !== 2'd0 || tie0 !== 1'b0 || out_valid1 !== 1'b0) begin
      n_err++;
      $display("FAIL midflight_reset: got v=%b idx=%0d max=%0h tie=%b v1=%b, want all 0", out_valid0, idx0, max0, tie0, out_valid1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready0 !== 1'b1) begin
      n_err++;
      $display("FAIL midflight_ready: got in_ready=%b, want 1", in_ready0);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_err++;
      $display("FAIL midflight_stale: got %0d stale valid cycles, want 0", stale);
    end
  endtask

  task automatic test_n8_onehot();
    int lat;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int j = 0; j < 8; j++) d8[j*16 +: 16] = (j == k) ? 16'hFFFF : 16'h0001;
      v8 = 1'b1; ordy8 = 1'b1;
      @(negedge clk);
      v8 = 1'b0;
      lat = 1;
      while (!ov8 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      n_cmp++;
      if (lat != 3 || idx8 !== 3'(k) || max8 !== 16'hFFFF || tie8 !== 1'b0) begin
        n_err++;
        $display("FAIL n8_onehot[%0d]: got lat=%0d idx=%0d max=%0h tie=%b, want 3/%0d/ffff/0", k, lat, idx8, max8, tie8, k);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_n2();
    logic [15:0] pat [3];
    int ei [3];
    int em [3];
    bit et [3];
    int lat;
    pat = '{16'h03_05, 16'h05_03, 16'h07_07};
    ei  = '{0, 1, 1};
    em  = '{5, 5, 7};
    et  = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v2 = 1'b1; d2 = pat[i]; ordy2 = 1'b1;
      @(negedge clk);
      v2 = 1'b0;
      lat = 1;
      while (!ov2 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      n_cmp++;
      if (lat != 1 || idx2 !== 1'(ei[i]) || max2 !== 8'(em[i]) || tie2 !== et[i]) begin
        n_err++;
        $display("FAIL n2[%0d]: got lat=%0d idx=%0d max=%0h tie=%b, want 1/%0d/%0h/%b", i, lat, idx2, max2, tie2, ei[i], em[i], et[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int sent;
    bit stall_prev;
    logic [11:0] snap;
    exp_t e;
    sent = 0; stall_prev = 1'b0; snap = '0;
    q0.delete(); q1.delete();
    for (int c = 0; c < 8000 && (sent < 1000 || q0.size() != 0 || q1.size() != 0); c++) begin
      @(negedge clk);
      if (stall_prev) begin
        n_cmp++;
        if ({out_valid0, idx0, max0, tie0} !== snap) begin
          n_err++;
          $display("FAIL rand_stable c=%0d: got %h, want %h", c, {out_valid0, idx0, max0, tie0}, snap);
        end
      end
      in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
      in_data   = ($urandom_range(0, 3) == 0) ? {4{8'($urandom_range(0, 3))}} ^ 32'($urandom_range(0, 3)) : $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid0 && out_ready) begin
        n_cmp++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra_m0: got idx=%0d max=%0h, want no result", idx0, max0);
        end else begin
          e = q0.pop_front();
          if (idx0 !== 2'(e.idx) || max0 !== 8'(e.mx) || tie0 !== e.tie) begin
            n_err++;
            $display("FAIL rand_m0: got idx=%0d max=%0h tie=%b, want %0d/%0h/%b", idx0, max0, tie0, e.idx, e.mx, e.tie);
          end
        end
      end
      if (out_valid1 && out_ready) begin
        n_cmp++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra_m1: got idx=%0d max=%0h, want no result", idx1, max1);
        end else begin
          e = q1.pop_front();
          if (idx1 !== 2'(e.idx) || max1 !== 8'(e.mx) || tie1 !== e.tie) begin
            n_err++;
            $display("FAIL rand_m1: got idx=%0d max=%0h tie=%b, want %0d/%0h/%b", idx1, max1, tie1, e.idx, e.mx, e.tie);
          end
        end
      end
      if (in_valid && in_ready0) begin
        q0.push_back(ref_scan({96'h0, in_data}, 4, 8, 0));
        q1.push_back(ref_scan({96'h0, in_data}, 4, 8, 1));
        sent++;
      end
      stall_prev = out_valid0 && !out_ready;
      snap = {out_valid0, idx0, max0, tie0};
    end
    n_cmp++;
    if (sent != 1000 || q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL rand_count: got sent=%0d left=%0d/%0d, want 1000/0/0", sent, q0.size(), q1.size());
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_reset_midflight();
    test_n8_onehot();
    test_n2();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
